mem_stage_access_unit: RTL and testbench

- Consumes the EX/MEM pipeline register outputs and performs the data-memory access for lw/lh/lb/sw/sh/sb.
- Drives a req/ack data-memory bus and stalls the pipeline until the access completes.
- Performs byte-lane steering for stores and alignment plus sign extension for loads.
- Returns load data to the MEM/WB register.

---
 rtl/mem_stage_access_unit.sv | 103 ++++++++++
 tb/tb_mem_stage_access_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access_unit.sv
// mem_stage_access_unit: MEM-stage lw/lh/lb/sw/sh/sb access over a req/ack bus with pipeline stall.
// Define MEM_ACCESS_TIMEOUT_EN to abort a BUSY access after TIMEOUT_CYCLES cycles without Mem_Ack.
module mem_stage_access_unit #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              R_Enable_In,
  input  logic              W_Enable_In,
  input  logic [1:0]        R_Width_In,
  input  logic [1:0]        W_Width_In,
  input  logic [ADDR_W-1:0] ALUResult_In,
  input  logic [31:0]       RegData2_In,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_WData,
  output logic [3:0]        Mem_ByteEn,
  input  logic              Mem_Ack,
  input  logic [31:0]       Mem_RData,
  output logic [31:0]       Load_Data_Out,
  output logic              Stall,
  output logic              Access_Error
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be positive");
  end
  logic [1:0] state;
  logic rd_q;
  logic [1:0] width_q, lo_q;
  logic [1:0] width, lo;
  logic any_en, illegal, legal, timeout;
  logic [3:0] byte_en;
  logic [31:0] wdata, rsh, ld_val;
  logic [15:0] rd_half;
  always_comb begin
    width = R_Enable_In ? R_Width_In : W_Width_In;
    lo = ALUResult_In[1:0];
    any_en = R_Enable_In | W_Enable_In;
    illegal = (R_Enable_In & W_Enable_In) | (width == 2'b11) |
              (width == 2'b01 & lo[0]) | (width == 2'b00 & lo != 2'b00);
    legal = any_en & ~illegal;
    Stall = (state == IDLE && legal) || state == BUSY;
    byte_en = (R_Enable_In || width == 2'b00) ? 4'b1111 :
              width == 2'b01 ? 4'b0011 << {lo[1], 1'b0} : 4'b0001 << lo;
    wdata = width == 2'b00 ? RegData2_In :
            width == 2'b01 ? {2{RegData2_In[15:0]}} : {4{RegData2_In[7:0]}};
    // Loads shift the addressed lane down to bit 0 before sign extension
    rsh = Mem_RData >> {lo_q, 3'b000};
    rd_half = lo_q[1] ? Mem_RData[31:16] : Mem_RData[15:0];
    ld_val = width_q == 2'b00 ? Mem_RData :
             width_q == 2'b01 ? {{16{rd_half[15]}}, rd_half} : {{24{rsh[7]}}, rsh[7:0]};
  end
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) cnt <= '0;
    else cnt <= (state == BUSY && !Mem_Ack) ? cnt + 1'b1 : '0;
  assign timeout = state == BUSY && !Mem_Ack && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      Mem_Req <= 1'b0;
      Mem_We <= 1'b0;
      Mem_Addr <= '0;
      Mem_WData <= '0;
      Mem_ByteEn <= '0;
      Load_Data_Out <= '0;
      Access_Error <= 1'b0;
      rd_q <= 1'b0;
      width_q <= '0;
      lo_q <= '0;
    end else begin
      Access_Error <= 1'b0;
      if (state == IDLE) begin
        if (legal) begin
          state <= BUSY;
          Mem_Req <= 1'b1;
          Mem_We <= W_Enable_In;
          Mem_Addr <= {ALUResult_In[ADDR_W-1:2], 2'b00};
          Mem_WData <= wdata;
          Mem_ByteEn <= byte_en;
          rd_q <= R_Enable_In;
          width_q <= width;
          lo_q <= lo;
        end else if (any_en) Access_Error <= 1'b1;
      end else if (state == BUSY) begin
        if (Mem_Ack || timeout) begin
          state <= DONE;
          Mem_Req <= 1'b0;
          Access_Error <= ~Mem_Ack;
          if (rd_q) Load_Data_Out <= Mem_Ack ? ld_val : 32'd0;
        end
      end else state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mem_stage_access_unit.sv
// tb_mem_stage_access_unit: randomized and directed checks of mem_stage_access_unit against a behavioural model.
module tb_mem_stage_access_unit;
  logic Clock = 0, Reset_n = 0;
  logic R_Enable_In = 0, W_Enable_In = 0;
  logic [1:0] R_Width_In = 0, W_Width_In = 0;
  logic [31:0] ALUResult_In = 0, RegData2_In = 0;
  logic Mem_Req, Mem_We, Mem_Ack = 0, Stall, Access_Error;
  logic [31:0] Mem_Addr, Mem_WData, Mem_RData = 0, Load_Data_Out;
  logic [3:0] Mem_ByteEn;
  int tests = 0, fails = 0;
  logic [31:0] exp_load = 0;

  mem_stage_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .R_Enable_In(R_Enable_In), .W_Enable_In(W_Enable_In),
    .R_Width_In(R_Width_In), .W_Width_In(W_Width_In), .ALUResult_In(ALUResult_In),
    .RegData2_In(RegData2_In), .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
    .Mem_WData(Mem_WData), .Mem_ByteEn(Mem_ByteEn), .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData),
    .Load_Data_Out(Load_Data_Out), .Stall(Stall), .Access_Error(Access_Error));

  always #5 Clock = ~Clock;

  function automatic bit illegal_f(bit rd, bit wr, int w, logic [31:0] a);
    return (rd && wr) || w == 3 || (w == 1 && a % 2 != 0) || (w == 0 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] exp_be(bit rd, int w, logic [31:0] a);
    if (rd || w == 0) return 4'd15;
    if (w == 1) return (a % 4 >= 2) ? 4'd12 : 4'd3;
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wd(int w, logic [31:0] d);
    if (w == 0) return d;
    if (w == 1) return (d & 32'hFFFF) * 32'h00010001;
    return (d & 32'hFF) * 32'h01010101;
  endfunction

  function automatic logic [31:0] exp_ld(int w, logic [31:0] a, logic [31:0] r);
    logic [31:0] v;
    if (w == 0) return r;
    if (w == 1) begin
      v = (r >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      return v >= 32'h8000 ? v + 32'hFFFF0000 : v;
    end
    v = (r >> (8 * (a % 4))) & 32'hFF;
    return v >= 32'h80 ? v + 32'hFFFFFF00 : v;
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drop();
    R_Enable_In = 0;
    W_Enable_In = 0;
  endtask

  // One instruction from EX/MEM; inputs held until DONE, ack arrives in BUSY cycle d.
  task automatic access(bit rd, bit wr, logic [1:0] rw, logic [1:0] ww, logic [31:0] a,
                        logic [31:0] d, logic [31:0] r, int dly);
    int w;
    bit bad, any;
    w = rd ? int'(rw) : int'(ww);
    any = rd || wr;
    bad = illegal_f(rd, wr, w, a);
    R_Enable_In = rd; W_Enable_In = wr; R_Width_In = rw; W_Width_In = ww;
    ALUResult_In = a; RegData2_In = d;
    #1;
    tests++;
    if (Stall !== (any && !bad)) begin fails++; $display("FAIL idle_stall got %b exp %b a=%h", Stall, any && !bad, a); end
    if (!any || bad) begin
      step();
      tests++;
      if (Access_Error !== any || Mem_Req !== 0 || Stall !== 0 || Load_Data_Out !== exp_load) begin
        fails++;
        $display("FAIL reject err=%b req=%b stall=%b ld=%h exp err=%b req=0 stall=0 ld=%h", Access_Error, Mem_Req, Stall, Load_Data_Out, any, exp_load);
      end
      drop();
      step();
      tests++;
      if (Access_Error !== 0) begin fails++; $display("FAIL err_pulse got %b exp 0", Access_Error); end
      return;
    end
    step();
    tests++;
    if (Mem_Req !== 1 || Mem_We !== wr || Mem_Addr !== (a & 32'hFFFFFFFC) || Mem_ByteEn !== exp_be(rd, w, a) || Access_Error !== 0) begin
      fails++;
      $display("FAIL issue req=%b we=%b addr=%h be=%b err=%b exp req=1 we=%b addr=%h be=%b err=0", Mem_Req, Mem_We, Mem_Addr, Mem_ByteEn, Access_Error, wr, a & 32'hFFFFFFFC, exp_be(rd, w, a));
    end
    if (wr) begin
      tests++;
      if (Mem_WData !== exp_wd(w, d)) begin fails++; $display("FAIL wdata got %h exp %h", Mem_WData, exp_wd(w, d)); end
    end
    for (int c = 1; c <= dly; c++) begin
      tests++;
      if (Stall !== 1 || Mem_Req !== 1 || Mem_Addr !== (a & 32'hFFFFFFFC)) begin
        fails++;
        $display("FAIL busy_hold stall=%b req=%b addr=%h exp 1 1 %h", Stall, Mem_Req, Mem_Addr, a & 32'hFFFFFFFC);
      end
      Mem_Ack = (c == dly);
      Mem_RData = (c == dly) ? r : $urandom;
      step();
    end
    Mem_Ack = 0;
    if (rd) exp_load = exp_ld(w, a, r);
    tests++;
    if (Stall !== 0 || Mem_Req !== 0 || Load_Data_Out !== exp_load || Access_Error !== 0) begin
      fails++;
      $display("FAIL done stall=%b req=%b ld=%h err=%b exp 0 0 %h 0", Stall, Mem_Req, Load_Data_Out, Access_Error, exp_load);
    end
    drop();
    step();
    tests++;
    if (Mem_Req !== 0 || Stall !== 0) begin fails++; $display("FAIL no_reissue req=%b stall=%b exp 0 0", Mem_Req, Stall); end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (Mem_Req !== 0 || Mem_We !== 0 || Mem_Addr !== 0 || Mem_WData !== 0 || Mem_ByteEn !== 0 ||
        Load_Data_Out !== 0 || Access_Error !== 0 || Stall !== 0) begin
      fails++;
      $display("FAIL reset req=%b we=%b addr=%h wd=%h be=%b ld=%h err=%b stall=%b exp all 0", Mem_Req, Mem_We, Mem_Addr, Mem_WData, Mem_ByteEn, Load_Data_Out, Access_Error, Stall);
    end
    step();
    step();
    Reset_n = 1;
    step();
  endtask

  task automatic test_loads();
    access(1, 0, 2'b00, 2'b00, 32'h100, 0, 32'hDEADBEEF, 2);
    tests++;
    if (Load_Data_Out !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_value got %h exp deadbeef", Load_Data_Out); end
    access(1, 0, 2'b10, 2'b00, 32'h103, 0, 32'h80FF1234, 1);
    tests++;
    if (Load_Data_Out !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_value got %h exp ffffff80", Load_Data_Out); end
    access(1, 0, 2'b01, 2'b00, 32'h102, 0, 32'h80FF1234, 3);
    tests++;
    if (Load_Data_Out !== 32'hFFFF80FF) begin fails++; $display("FAIL lh_value got %h exp ffff80ff", Load_Data_Out); end
  endtask

  task automatic test_stores();
    access(0, 1, 2'b00, 2'b10, 32'h101, 32'h000000AB, 0, 1);
    access(0, 1, 2'b00, 2'b01, 32'h102, 32'h00001234, 0, 2);
    access(0, 1, 2'b00, 2'b00, 32'h104, 32'hCAFEF00D, 0, 1);
  endtask

  task automatic test_illegal();
    access(1, 0, 2'b00, 2'b00, 32'h102, 0, 0, 1);
    access(1, 1, 2'b00, 2'b00, 32'h100, 0, 0, 1);
    access(0, 1, 2'b00, 2'b11, 32'h100, 32'h55, 0, 1);
    access(1, 0, 2'b01, 2'b00, 32'h101, 0, 0, 1);
  endtask

  task automatic test_ack_ignored();
    Mem_Ack = 1;
    Mem_RData = 32'h12345678;
    step();
    Mem_Ack = 0;
    tests++;
    if (Mem_Req !== 0 || Stall !== 0 || Load_Data_Out !== exp_load) begin
      fails++;
      $display("FAIL stray_ack req=%b stall=%b ld=%h exp 0 0 %h", Mem_Req, Stall, Load_Data_Out, exp_load);
    end
  endtask

  task automatic test_reset_mid_access();
    R_Enable_In = 1; R_Width_In = 2'b00; ALUResult_In = 32'h200;
    step();
    tests++;
    if (Mem_Req !== 1 || Stall !== 1) begin fails++; $display("FAIL rst_busy req=%b stall=%b exp 1 1", Mem_Req, Stall); end
    drop();
    Reset_n = 0;
    #1;
    exp_load = 0;
    tests++;
    if (Mem_Req !== 0 || Stall !== 0 || Load_Data_Out !== exp_load) begin
      fails++;
      $display("FAIL rst_abort req=%b stall=%b ld=%h exp 0 0 0", Mem_Req, Stall, Load_Data_Out);
    end
    step();
    Reset_n = 1;
    Mem_Ack = 1;
    step();
    Mem_Ack = 0;
    tests++;
    if (Mem_Req !== 0 || Access_Error !== 0 || Load_Data_Out !== exp_load) begin
      fails++;
      $display("FAIL rst_no_complete req=%b err=%b ld=%h exp 0 0 %h", Mem_Req, Access_Error, Load_Data_Out, exp_load);
    end
    access(0, 1, 2'b00, 2'b00, 32'h300, 32'h0BADC0DE, 0, 1);
  endtask

  task automatic test_back_to_back();
    access(1, 0, 2'b00, 2'b00, 32'h400, 0, 32'h11223344, 1);
    access(1, 0, 2'b10, 2'b00, 32'h401, 0, 32'h11223344, 1);
    access(0, 1, 2'b00, 2'b10, 32'h402, 32'h99, 0, 1);
    tests++;
    if (Load_Data_Out !== 32'h00000033) begin fails++; $display("FAIL store_keeps_load got %h exp 00000033", Load_Data_Out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int k;
      bit rd, wr;
      logic [1:0] rw, ww;
      k = int'($urandom_range(0, 9));
      rd = (k == 1) || (k >= 2 && k <= 5);
      wr = (k == 1) || k >= 6;
      rw = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      ww = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      access(rd, wr, rw, ww, $urandom, $urandom, $urandom, int'($urandom_range(1, 4)));
    end
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    R_Enable_In = 1; R_Width_In = 2'b00; ALUResult_In = 32'h500;
    step();
    for (int c = 0; c < 4; c++) begin
      tests++;
      if (Stall !== 1 || Mem_Req !== 1) begin fails++; $display("FAIL to_busy c=%0d stall=%b req=%b exp 1 1", c, Stall, Mem_Req); end
      step();
    end
    exp_load = 0;
    tests++;
    if (Access_Error !== 1 || Mem_Req !== 0 || Stall !== 0 || Load_Data_Out !== 0) begin
      fails++;
      $display("FAIL timeout err=%b req=%b stall=%b ld=%h exp 1 0 0 0", Access_Error, Mem_Req, Stall, Load_Data_Out);
    end
    drop();
    step();
    tests++;
    if (Access_Error !== 0) begin fails++; $display("FAIL to_pulse got %b exp 0", Access_Error); end
  endtask
`endif

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_illegal();
    test_ack_ignored();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
